// File: rtl/bcd_disp_pkg.sv
// Shared types and segment patterns for the BCD display driver.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package bcd_disp_pkg;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_ERR   = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic nib_invalid(input logic [3:0] n);
    return n > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_seg_decoder.sv
// Combinational nibble to 7-segment decode with blanking.
// Ports: nibble, blank in; seg (active-low), invalid (A-F) out.
module bcd_seg_decoder
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       invalid
);

  always_comb begin
    invalid = nib_invalid(nibble);
    seg     = SEG_ERR;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_ERR;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_driver.sv
// Multiplexed 4-digit 7-segment driver for a held BCD result.
// Ports: clk, reset, result_valid, result_bcd in; seg, an, digit_err out.
module bcd_display_driver
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_ZEROS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        result_valid,
  input  logic [15:0] result_bcd,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        digit_err
);

  localparam int CW =
    (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(REFRESH_DIV - 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   hold;
  logic          load;
  logic          wrap;
  logic [3:0]    zero_up;
  logic [3:0]    blank_d;
  logic [3:0]    inv;
  logic [6:0]    seg_d [4];

  assign wrap = (state == SCAN) && (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == IDLE && result_valid)
      state_nx = SCAN;
  end

  // load marks the first cycle of a refresh slot, so
  // a capture mid-slot only shows up at the next slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      idx  <= 2'd0;
      load <= 1'b0;
    end else if (state == IDLE) begin
      cnt  <= '0;
      idx  <= 2'd0;
      load <= result_valid;
    end else begin
      cnt  <= wrap ? '0 : cnt + 1'b1;
      load <= wrap;
      if (wrap) idx <= idx + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             hold <= 16'h0000;
    else if (result_valid) hold <= result_bcd;
  end

  // zero_up[i]: digit i and everything above it are 0.
  always_comb begin
    zero_up[3] = hold[15:12] == 4'd0;
    zero_up[2] = zero_up[3] && hold[11:8] == 4'd0;
    zero_up[1] = zero_up[2] && hold[7:4] == 4'd0;
    zero_up[0] = 1'b0;
    blank_d    = BLANK_ZEROS ? zero_up : 4'b0000;
  end

  for (genvar g = 0; g < 4; g++) begin : g_dec
    bcd_seg_decoder u_dec (
      .nibble  (hold[4*g +: 4]),
      .blank   (blank_d[g]),
      .seg     (seg_d[g]),
      .invalid (inv[g])
    );
  end

  assign digit_err = |inv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else if (state == IDLE) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else if (load) begin
      an  <= ~(4'b0001 << idx);
      seg <= seg_d[idx];
    end
  end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed scoreboard bench for bcd_display_driver.
// Two instances (blanking on/off) share one stimulus.
module tb_bcd_display_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        result_valid;
  logic [15:0] result_bcd;
  logic [6:0]  seg_b, seg_n;
  logic [3:0]  an_b, an_n;
  logic        err_b, err_n;

  always #5 clk = ~clk;

  bcd_display_driver #(
    .REFRESH_DIV (4),
    .BLANK_ZEROS (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .result_valid (result_valid),
    .result_bcd   (result_bcd),
    .seg          (seg_b),
    .an           (an_b),
    .digit_err    (err_b)
  );

  bcd_display_driver #(
    .REFRESH_DIV (4),
    .BLANK_ZEROS (1'b0)
  ) dut_nb (
    .clk          (clk),
    .reset        (reset),
    .result_valid (result_valid),
    .result_bcd   (result_bcd),
    .seg          (seg_n),
    .an           (an_n),
    .digit_err    (err_n)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg_b;
    logic [6:0] seg_n;
  } exp_t;

  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int edges = 0;
  bit scanning = 0;
  logic [3:0] cur_an  = 4'b1111;
  logic [6:0] cur_sb  = 7'h7f;
  logic [6:0] cur_sn  = 7'h7f;
  logic       cur_err = 1'b0;

  function automatic logic [6:0] ref_seg(
    input logic [15:0] h, input int i, input bit bz);
    logic [3:0]  n;
    logic [15:0] up;
    n  = h[4*i +: 4];
    up = h >> (4 * i);
    if (bz && i != 0 && up == 16'h0) return 7'b1111111;
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0000110;
    endcase
  endfunction

  function automatic logic ref_err(input logic [15:0] h);
    logic e;
    e = 1'b0;
    for (int i = 0; i < 4; i++)
      if (h[4*i +: 4] > 4'd9) e = 1'b1;
    return e;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h t=%0t",
             tag, got, exp, $time);
    end
  endtask

  task automatic check_now();
    chk("disp_bz", {21'd0, an_b, seg_b},
                   {21'd0, cur_an, cur_sb});
    chk("disp_nb", {21'd0, an_n, seg_n},
                   {21'd0, cur_an, cur_sn});
    chk("digit_err", {30'd0, err_b, err_n},
                     {30'd0, cur_err, cur_err});
  endtask

  // One clock; on slot-load edges pop the next expectation.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (scanning) begin
      edges++;
      if (edges % 4 == 1) begin
        if (exp_q.size() == 0) begin
          chk("queue_empty", 32'd1, 32'd0);
        end else begin
          e      = exp_q.pop_front();
          cur_an = e.an;
          cur_sb = e.seg_b;
          cur_sn = e.seg_n;
        end
      end
    end
    check_now();
  endtask

  task automatic run_loads(input int n);
    int seen;
    seen = 0;
    for (int k = 0; k < 400 && seen < n; k++) begin
      cycle();
      if (scanning && edges % 4 == 1) seen++;
    end
    if (seen < n) chk("load_timeout", 32'd1, 32'd0);
  endtask

  // Drive a one-cycle strobe; queue the next 8 slots.
  task automatic strobe(input logic [15:0] v);
    exp_t       e;
    logic [3:0] a;
    int         c, f, i;
    result_valid = 1'b1;
    result_bcd   = v;
    if (!scanning) begin
      scanning = 1;
      edges    = -1;
    end
    c = edges + 1;
    f = c + 1;
    while (f % 4 != 1) f++;
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      i       = ((f + 4 * k - 1) / 4) % 4;
      a       = 4'b0001 << i;
      e.an    = ~a;
      e.seg_b = ref_seg(v, i, 1'b1);
      e.seg_n = ref_seg(v, i, 1'b0);
      exp_q.push_back(e);
    end
    cur_err = ref_err(v);
    cycle();
    result_valid = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    result_valid = 1'b0;
    result_bcd   = 16'h0;
    #1 reset = 1'b1;
    #1 check_now();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    repeat (100) cycle();

    strobe(16'h1234);
    run_loads(8);

    strobe(16'h0007);
    run_loads(8);

    strobe(16'h0A05);
    run_loads(8);

    strobe(16'h0005);
    run_loads(4);

    strobe(16'h9999);
    run_loads(3);
    for (int k = 0; k < 8 && edges % 4 != 3; k++)
      cycle();
    strobe(16'h0001);
    run_loads(6);

    run_loads(1);
    #2 reset = 1'b1;
    cur_an  = 4'b1111;
    cur_sb  = 7'h7f;
    cur_sn  = 7'h7f;
    cur_err = 1'b0;
    #1 check_now();
    scanning = 0;
    exp_q.delete();
    cycle();
    reset = 1'b0;
    repeat (20) cycle();

    strobe(16'h0042);
    run_loads(4);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
